// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides clk into a pixel strobe, scans the pixel raster and
// produces active-low syncs plus the coordinates and visible-area flag for RGB generators.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       x_next;
    logic [9:0]       y_next;

    assign p_tick      = (div_cnt == DIV_LAST);
    assign frame_start = p_tick && (pixel_x == '0) && (pixel_y == '0);

    // NOTE: defaults first so every path assigns x_next/y_next; otherwise a latch is inferred.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                x_next = '0;
                y_next = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
            end else begin
                x_next = pixel_x + 1'b1;
            end
        end
    end

    // Syncs and video_on decode the next-state counters so they line up with pixel_x/pixel_y.
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b1;
        end else begin
            div_cnt  <= p_tick ? '0 : div_cnt + 1'b1;
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            hsync    <= !((x_next >= HS_FIRST) && (x_next <= HS_LAST));
            vsync    <= !((y_next >= VS_FIRST) && (y_next <= VS_LAST));
            video_on <= (x_next < H_VIS) && (y_next < V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance and a shrunken-raster instance share clk/reset
// and are compared every cycle with a raster model driven by the edge count since reset.
module tb_vga_sync_gen;

    // Shrunken raster so whole frames fit in a short run: 15 x 10 pixels, 600 clk per frame.
    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 6, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int TD   = 4;

    typedef struct {
        logic hsync;
        logic vsync;
        logic video_on;
        logic p_tick;
        logic frame_start;
        int   x;
        int   y;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       d_hsync, d_vsync, d_video_on, d_p_tick, d_frame_start;
    logic [9:0] d_x, d_y;
    logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_frame_start;
    logic [9:0] s_x, s_y;

    int n_total = 0;
    int n_pass  = 0;
    int n       = 0;   // clk edges since the last edge that saw reset high

    always #5 clk = ~clk;

    vga_sync_gen dut_def (
        .clk(clk), .reset(reset),
        .hsync(d_hsync), .vsync(d_vsync), .video_on(d_video_on), .p_tick(d_p_tick),
        .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_frame_start)
    );

    vga_sync_gen #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
        .TICK_DIV(TD)
    ) dut_small (
        .clk(clk), .reset(reset),
        .hsync(s_hsync), .vsync(s_vsync), .video_on(s_video_on), .p_tick(s_p_tick),
        .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_frame_start)
    );

    // Raster position follows from how many pixel strobes have elapsed since reset.
    function automatic exp_t model(input int cyc, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs,
                                   input int vb, input int td);
        exp_t e;
        int ht, vt, lin;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        lin = (cyc / td) % (ht * vt);
        e.x = lin % ht;
        e.y = lin / ht;
        e.p_tick      = (cyc % td) == td - 1;
        e.hsync       = !(e.x >= hd + hf && e.x < hd + hf + hs);
        e.vsync       = !(e.y >= vd + vf && e.y < vd + vf + vs);
        e.video_on    = (e.x < hd) && (e.y < vd);
        e.frame_start = e.p_tick && e.x == 0 && e.y == 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d (cycle %0d after reset)", tag, obs, expv, n);
    endtask

    task automatic check_all();
        exp_t ed, es;
        ed = model(n, 640, 16, 96, 48, 480, 10, 2, 33, TD);
        es = model(n, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, TD);
        check("def_hsync",       32'(d_hsync),       32'(ed.hsync));
        check("def_vsync",       32'(d_vsync),       32'(ed.vsync));
        check("def_video_on",    32'(d_video_on),    32'(ed.video_on));
        check("def_p_tick",      32'(d_p_tick),      32'(ed.p_tick));
        check("def_frame_start", 32'(d_frame_start), 32'(ed.frame_start));
        check("def_x",           32'(d_x),           32'(ed.x));
        check("def_y",           32'(d_y),           32'(ed.y));
        check("sm_hsync",        32'(s_hsync),       32'(es.hsync));
        check("sm_vsync",        32'(s_vsync),       32'(es.vsync));
        check("sm_video_on",     32'(s_video_on),    32'(es.video_on));
        check("sm_p_tick",       32'(s_p_tick),      32'(es.p_tick));
        check("sm_frame_start",  32'(s_frame_start), 32'(es.frame_start));
        check("sm_x",            32'(s_x),           32'(es.x));
        check("sm_y",            32'(s_y),           32'(es.y));
    endtask

    // One clk edge; the model counter follows the reset level seen by that edge,
    // then outputs are compared on the falling edge.
    task automatic step();
        @(posedge clk);
        n = reset ? 0 : n + 1;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int hs_low, fall_x, fs_seen, fs_last, von_cnt, vs_low;
        logic prev_hs;

        // Reset state
        reset = 1'b1;
        repeat (3) step();

        // Startup and tick cadence: strobe every 4th clk, x reaches 10 after 40 clk
        @(negedge clk) reset = 1'b0;
        repeat (40) step();
        check("def_x_after_40", 32'(d_x), 32'd10);

        // Restart, then one default line plus several shrunken frames
        reset = 1'b1;
        step();
        reset = 1'b0;
        hs_low = 0; fall_x = -1; prev_hs = 1'b1;
        fs_seen = 0; fs_last = 0; von_cnt = 0; vs_low = 0;
        repeat (3300) begin
            step();
            if (n < 3200 && !d_hsync) hs_low++;
            if (prev_hs && !d_hsync && fall_x < 0) fall_x = int'(d_x);
            prev_hs = d_hsync;
            if (n == 3199) check("line_end_x", 32'(d_x), 32'd799);
            if (n == 3200) check("line_wrap_y", 32'(d_y), 32'd1);
            if (s_frame_start) begin
                if (fs_seen > 0) begin
                    check("sm_frame_period", 32'(n - fs_last), 32'(600));
                    check("sm_video_on_clk", 32'(von_cnt), 32'(S_HD * S_VD * TD));
                    check("sm_vsync_low_clk", 32'(vs_low), 32'(S_VS * 15 * TD));
                end
                fs_seen++; fs_last = n; von_cnt = 0; vs_low = 0;
            end
            if (s_video_on) von_cnt++;
            if (!s_vsync) vs_low++;
        end
        check("def_hsync_low_clk", 32'(hs_low), 32'd384);
        check("def_hsync_fall_x", 32'(fall_x), 32'd656);
        check("sm_frames_seen", 32'(fs_seen), 32'd6);

        // Random run lengths with resets of random length landing anywhere in the frame
        repeat (20) begin
            repeat ($urandom_range(1500, 1)) step();
            reset = 1'b1;
            repeat ($urandom_range(3, 1)) step();
            reset = 1'b0;
        end
        repeat (50) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
